// File: rtl/updown_counter_param.sv
// Parametrised modulo up/down counter with wrap or saturate policy, parallel
// load with clamp, terminal-count flag, registered wrap pulse and sticky overflow.
module updown_counter_param #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             moving,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam longint unsigned MAX_LIMIT = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX);
  localparam logic             SAT_C    = (SATURATE != 0);
  localparam logic [WIDTH-1:0] ZERO_C   = '0;
  localparam logic [WIDTH-1:0] ONE_C    = WIDTH'(1);

  localparam logic [1:0] MODE_CLR  = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("updown_counter_param: WIDTH must be in 2..32");
    end
    if (MAX < 64'd1 || MAX > MAX_LIMIT) begin : g_bad_max
      $error("updown_counter_param: MAX must be in 1..2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             ovf_r;

  logic [WIDTH-1:0] next_count_s;
  logic             next_wrap_s;
  logic             ovf_set_s;
  logic             active_s;
  logic             tc_s;
  logic             moving_s;

  assign active_s = en & ~load;

  // Terminal-count and moving flags, combinational from the present inputs
  always_comb begin
    tc_s     = 1'b0;
    moving_s = 1'b0;
    if (active_s) begin
      tc_s     = ((mode == MODE_UP) && (count_r == MAX_C)) ||
                 ((mode == MODE_DOWN) && (count_r == ZERO_C));
      moving_s = ((mode == MODE_UP) || (mode == MODE_DOWN)) && !(SAT_C && tc_s);
    end else begin
      tc_s     = 1'b0;
      moving_s = 1'b0;
    end
  end

  // Next-state selection: load beats enable; out-of-range counts recover to 0 on any step
  always_comb begin
    next_count_s = count_r;
    next_wrap_s  = 1'b0;
    ovf_set_s    = 1'b0;
    if (load) begin
      if (load_value > MAX_C) begin
        next_count_s = MAX_C;
        ovf_set_s    = 1'b1;
      end else begin
        next_count_s = load_value;
      end
    end else if (en) begin
      case (mode)
        MODE_CLR: begin
          next_count_s = ZERO_C;
        end
        MODE_UP: begin
          if (count_r > MAX_C) begin
            next_count_s = ZERO_C;
          end else if (count_r == MAX_C) begin
            ovf_set_s    = 1'b1;
            next_count_s = SAT_C ? MAX_C : ZERO_C;
            next_wrap_s  = ~SAT_C;
          end else begin
            next_count_s = count_r + ONE_C;
          end
        end
        MODE_DOWN: begin
          if (count_r > MAX_C) begin
            next_count_s = ZERO_C;
          end else if (count_r == ZERO_C) begin
            ovf_set_s    = 1'b1;
            next_count_s = SAT_C ? ZERO_C : MAX_C;
            next_wrap_s  = ~SAT_C;
          end else begin
            next_count_s = count_r - ONE_C;
          end
        end
        MODE_HOLD: begin
          next_count_s = count_r;
        end
        default: begin
          next_count_s = count_r;
        end
      endcase
    end else begin
      next_count_s = count_r;
    end
  end

  // State registers; a set condition overrides a coincident overflow clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      wrap_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= next_count_s;
      wrap_r  <= next_wrap_s;
      ovf_r   <= ovf_set_s | (ovf_r & ~clr_ovf);
    end
  end

  assign count  = count_r;
  assign wrap   = wrap_r;
  assign ovf    = ovf_r;
  assign tc     = tc_s;
  assign moving = moving_s;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: a wrap-policy and a saturate-policy instance (WIDTH=4, MAX=9)
// driven from shared inputs, each checked against hand-computed values.
module tb_updown_counter_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_value;
  logic       clr_ovf;

  logic [3:0] count_w, count_s;
  logic       moving_w, moving_s, tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  updown_counter_param #(.WIDTH(4), .MAX(64'd9), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .load_value(load_value), .clr_ovf(clr_ovf), .count(count_w),
    .moving(moving_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
  );

  updown_counter_param #(.WIDTH(4), .MAX(64'd9), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .load_value(load_value), .clr_ovf(clr_ovf), .count(count_s),
    .moving(moving_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string tag, input logic [3:0] cw, input logic ow,
                          input logic [3:0] cs, input logic os);
    chk({tag, "_count_w"}, 32'(count_w), 32'(cw));
    chk({tag, "_ovf_w"},   32'(ovf_w),   32'(ow));
    chk({tag, "_count_s"}, 32'(count_s), 32'(cs));
    chk({tag, "_ovf_s"},   32'(ovf_s),   32'(os));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0;
    load_value = 4'd0; clr_ovf = 1'b0;
    #12;
    chk_both("reset", 4'd0, 1'b0, 4'd0, 1'b0);
    chk("reset_wrap_w", 32'(wrap_w), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Load clamp with enable/up also asserted: load wins
    load = 1'b1; load_value = 4'd13; en = 1'b1; mode = 2'b01;
    #1;
    chk("load_tc_w", 32'(tc_w), 32'd0);
    chk("load_moving_w", 32'(moving_w), 32'd0);
    step();
    chk_both("clamp", 4'd9, 1'b1, 4'd9, 1'b1);
    chk("clamp_wrap_w", 32'(wrap_w), 32'd0);
    load_value = 4'd4;
    step();
    chk_both("load4", 4'd4, 1'b1, 4'd4, 1'b1);
    load = 1'b0;
    step();
    chk_both("up5", 4'd5, 1'b1, 4'd5, 1'b1);

    // Reset asserted between edges clears everything asynchronously
    #2;
    reset = 1'b1;
    #1;
    chk_both("async_rst", 4'd0, 1'b0, 4'd0, 1'b0);
    chk("async_rst_wrap_w", 32'(wrap_w), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Up count 12 edges from 0: wrap instance 1..9,0,1,2; saturate instance sticks at 9
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("upw_count", 32'(count_w), 32'(i % 10));
      chk("upw_wrap",  32'(wrap_w),  (i == 10) ? 32'd1 : 32'd0);
      chk("upw_ovf",   32'(ovf_w),   (i >= 10) ? 32'd1 : 32'd0);
      chk("upw_tc",    32'(tc_w),    ((i % 10) == 9) ? 32'd1 : 32'd0);
      chk("ups_count", 32'(count_s), (i < 9) ? 32'(i) : 32'd9);
      chk("ups_wrap",  32'(wrap_s),  32'd0);
      chk("ups_ovf",   32'(ovf_s),   (i >= 10) ? 32'd1 : 32'd0);
      chk("ups_moving", 32'(moving_s), (i >= 9) ? 32'd0 : 32'd1);
    end

    // Overflow clear, then clear coinciding with a wrap: set wins
    clr_ovf = 1'b1; mode = 2'b11;
    step();
    chk_both("clr_ovf", 4'd2, 1'b0, 4'd9, 1'b0);
    clr_ovf = 1'b0; load = 1'b1; load_value = 4'd9;
    step();
    chk_both("load9", 4'd9, 1'b0, 4'd9, 1'b0);
    load = 1'b0; mode = 2'b01; clr_ovf = 1'b1;
    step();
    chk_both("race", 4'd0, 1'b1, 4'd9, 1'b1);
    chk("race_wrap_w", 32'(wrap_w), 32'd1);
    chk("race_wrap_s", 32'(wrap_s), 32'd0);

    // Down count from 2 for 4 edges
    load = 1'b1; load_value = 4'd2;
    step();
    chk_both("load2", 4'd2, 1'b0, 4'd2, 1'b0);
    load = 1'b0; clr_ovf = 1'b0; mode = 2'b10;
    step();
    chk_both("dn1", 4'd1, 1'b0, 4'd1, 1'b0);
    step();
    chk_both("dn2", 4'd0, 1'b0, 4'd0, 1'b0);
    chk("dn2_tc_s", 32'(tc_s), 32'd1);
    chk("dn2_moving_s", 32'(moving_s), 32'd0);
    chk("dn2_moving_w", 32'(moving_w), 32'd1);
    step();
    chk_both("dn3", 4'd9, 1'b1, 4'd0, 1'b1);
    chk("dn3_wrap_w", 32'(wrap_w), 32'd1);
    chk("dn3_wrap_s", 32'(wrap_s), 32'd0);
    step();
    chk_both("dn4", 4'd8, 1'b1, 4'd0, 1'b1);
    chk("dn4_wrap_w", 32'(wrap_w), 32'd0);
    chk("dn4_wrap_s", 32'(wrap_s), 32'd0);
    chk("dn4_moving_s", 32'(moving_s), 32'd0);

    // Hold, disabled clear, enabled clear
    load = 1'b1; load_value = 4'd7;
    step();
    chk_both("load7", 4'd7, 1'b1, 4'd7, 1'b1);
    load = 1'b0; mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_count_w", 32'(count_w), 32'd7);
      chk("hold_count_s", 32'(count_s), 32'd7);
      chk("hold_moving_w", 32'(moving_w), 32'd0);
    end
    en = 1'b0; mode = 2'b00;
    step();
    chk_both("dis_clr", 4'd7, 1'b1, 4'd7, 1'b1);
    en = 1'b1;
    step();
    chk_both("en_clr", 4'd0, 1'b1, 4'd0, 1'b1);
    chk("en_clr_wrap_w", 32'(wrap_w), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
